multicycle_ctrl: RTL and testbench

- Moore/Mealy control FSM that sequences a multi-cycle RISC-V datapath: shared memory, IR, A/B/ALUOut registers, one ALU.
- Supports LD, OP-IMM (addi/slti), SD, R-type and BEQ.
- Sits beside the datapath. Takes the opcode from the IR and a memory ready handshake. Drives every datapath enable and mux select, and counts retired instructions.

---
 rtl/multicycle_ctrl.sv | 160 ++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Control FSM for a multi-cycle RISC-V datapath (LD, SD, OP-IMM, R-type, BEQ).
// Datapath enables and mux selects decode from the state register; the instruction counter counts retired instructions.
module multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [6:0]       opcode_i,
    input  logic             mem_ready_i,
    output logic             PCWrite_o,
    output logic             PCWriteCond_o,
    output logic             PCSource_o,
    output logic             IorD_o,
    output logic             MemRead_o,
    output logic             MemWrite_o,
    output logic             IRWrite_o,
    output logic             RegWrite_o,
    output logic             MemtoReg_o,
    output logic [1:0]       ALUSrcA_o,
    output logic [1:0]       ALUSrcB_o,
    output logic [1:0]       ALU_op_o,
    output logic [3:0]       state_o,
    output logic             retire_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] instr_cnt_o
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEM_ADDR = 4'd3,
        S_MEM_RD   = 4'd4,
        S_MEM_WB   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_EXEC_R   = 4'd7,
        S_EXEC_I   = 4'd8,
        S_ALU_WB   = 4'd9,
        S_BRANCH   = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        PCWrite_o     = 1'b0;
        PCWriteCond_o = 1'b0;
        PCSource_o    = 1'b0;
        IorD_o        = 1'b0;
        MemRead_o     = 1'b0;
        MemWrite_o    = 1'b0;
        IRWrite_o     = 1'b0;
        RegWrite_o    = 1'b0;
        MemtoReg_o    = 1'b0;
        ALUSrcA_o     = 2'b00;
        ALUSrcB_o     = 2'b00;
        ALU_op_o      = 2'b00;
        retire_o      = 1'b0;
        illegal_o     = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                // IR and PC+4 load only in the cycle the memory delivers the word
                MemRead_o = 1'b1;
                ALUSrcB_o = 2'b01;
                IRWrite_o = mem_ready_i;
                PCWrite_o = mem_ready_i;
                if (mem_ready_i) state_d = S_FETCH_NEXT();
            end
            S_DECODE: begin
                ALUSrcB_o = 2'b10;
                case (opcode_i)
                    OP_LOAD, OP_STORE: state_d = S_MEM_ADDR;
                    OP_RTYPE:          state_d = S_EXEC_R;
                    OP_IMM:            state_d = S_EXEC_I;
                    OP_BRANCH:         state_d = S_BRANCH;
                    default:           state_d = S_TRAP;
                endcase
            end
            S_MEM_ADDR: begin
                ALUSrcA_o = 2'b01;
                ALUSrcB_o = 2'b10;
                state_d   = (opcode_i == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                MemRead_o = 1'b1;
                IorD_o    = 1'b1;
                if (mem_ready_i) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                RegWrite_o = 1'b1;
                MemtoReg_o = 1'b1;
                retire_o   = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WR: begin
                // a store completes in the handshake cycle itself
                MemWrite_o = 1'b1;
                IorD_o     = 1'b1;
                if (mem_ready_i) begin
                    retire_o = 1'b1;
                    state_d  = S_FETCH;
                end
            end
            S_EXEC_R: begin
                ALUSrcA_o = 2'b01;
                ALU_op_o  = 2'b10;
                state_d   = S_ALU_WB;
            end
            S_EXEC_I: begin
                ALUSrcA_o = 2'b01;
                ALUSrcB_o = 2'b10;
                ALU_op_o  = 2'b11;
                state_d   = S_ALU_WB;
            end
            S_ALU_WB: begin
                RegWrite_o = 1'b1;
                retire_o   = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA_o     = 2'b01;
                ALU_op_o      = 2'b01;
                PCWriteCond_o = 1'b1;
                PCSource_o    = 1'b1;
                retire_o      = 1'b1;
                state_d       = S_FETCH;
            end
            S_TRAP: illegal_o = 1'b1;
            default: state_d = S_IDLE;
        endcase
    end

    function automatic state_t S_FETCH_NEXT();
        return S_DECODE;
    endfunction

    assign cnt_d       = retire_o ? cnt_q + {{(CNT_W-1){1'b0}}, 1'b1} : cnt_q;
    assign state_o     = state_q;
    assign instr_cnt_o = cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class cycle by cycle
// against hand-derived state, control-vector and counter values.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [6:0]  opcode_i;
    logic        mem_ready_i;
    logic        PCWrite_o, PCWriteCond_o, PCSource_o, IorD_o, MemRead_o, MemWrite_o;
    logic        IRWrite_o, RegWrite_o, MemtoReg_o, retire_o, illegal_o;
    logic [1:0]  ALUSrcA_o, ALUSrcB_o, ALU_op_o;
    logic [3:0]  state_o;
    logic [31:0] instr_cnt_o;
    logic [16:0] ctrl;

    int tests_run = 0;
    int tests_failed = 0;

    multicycle_ctrl #(.CNT_W(32)) dut (
        .clk_i(clk), .rst_i(rst_i), .opcode_i(opcode_i), .mem_ready_i(mem_ready_i),
        .PCWrite_o(PCWrite_o), .PCWriteCond_o(PCWriteCond_o), .PCSource_o(PCSource_o),
        .IorD_o(IorD_o), .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o),
        .IRWrite_o(IRWrite_o), .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o),
        .ALUSrcA_o(ALUSrcA_o), .ALUSrcB_o(ALUSrcB_o), .ALU_op_o(ALU_op_o),
        .state_o(state_o), .retire_o(retire_o), .illegal_o(illegal_o),
        .instr_cnt_o(instr_cnt_o)
    );

    always #5 clk = ~clk;

    // {PCWrite,PCWriteCond,PCSource,IorD,MemRead,MemWrite,IRWrite,RegWrite,MemtoReg,SrcA,SrcB,ALUop,retire,illegal}
    assign ctrl = {PCWrite_o, PCWriteCond_o, PCSource_o, IorD_o, MemRead_o, MemWrite_o,
                   IRWrite_o, RegWrite_o, MemtoReg_o, ALUSrcA_o, ALUSrcB_o, ALU_op_o,
                   retire_o, illegal_o};

    localparam logic [16:0] C_IDLE    = 17'b0_0_0_0_0_0_0_0_0_00_00_00_0_0;
    localparam logic [16:0] C_FETCH_R = 17'b1_0_0_0_1_0_1_0_0_00_01_00_0_0;
    localparam logic [16:0] C_FETCH_W = 17'b0_0_0_0_1_0_0_0_0_00_01_00_0_0;
    localparam logic [16:0] C_DECODE  = 17'b0_0_0_0_0_0_0_0_0_00_10_00_0_0;
    localparam logic [16:0] C_MADDR   = 17'b0_0_0_0_0_0_0_0_0_01_10_00_0_0;
    localparam logic [16:0] C_MEM_RD  = 17'b0_0_0_1_1_0_0_0_0_00_00_00_0_0;
    localparam logic [16:0] C_MEM_WB  = 17'b0_0_0_0_0_0_0_1_1_00_00_00_1_0;
    localparam logic [16:0] C_MWR_W   = 17'b0_0_0_1_0_1_0_0_0_00_00_00_0_0;
    localparam logic [16:0] C_MWR_R   = 17'b0_0_0_1_0_1_0_0_0_00_00_00_1_0;
    localparam logic [16:0] C_EXEC_R  = 17'b0_0_0_0_0_0_0_0_0_01_00_10_0_0;
    localparam logic [16:0] C_EXEC_I  = 17'b0_0_0_0_0_0_0_0_0_01_10_11_0_0;
    localparam logic [16:0] C_ALU_WB  = 17'b0_0_0_0_0_0_0_1_0_00_00_00_1_0;
    localparam logic [16:0] C_BRANCH  = 17'b0_1_1_0_0_0_0_0_0_01_00_01_1_0;
    localparam logic [16:0] C_TRAP    = 17'b0_0_0_0_0_0_0_0_0_00_00_00_0_1;

    localparam logic [6:0] OP_LD = 7'b0000011, OP_SD = 7'b0100011, OP_R = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011, OP_BEQ = 7'b1100011, OP_BAD = 7'b1111111;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_now(input string tag, input logic [3:0] st, input logic [16:0] c,
                              input logic [31:0] cnt);
        chk({tag, ".state"}, {28'b0, state_o}, {28'b0, st});
        chk({tag, ".ctrl"}, {15'b0, ctrl}, {15'b0, c});
        chk({tag, ".cnt"}, instr_cnt_o, cnt);
        $display("[TB] %s state=%0d ctrl=%b cnt=%0d", tag, state_o, ctrl, instr_cnt_o);
    endtask

    // Advance one clock, apply this cycle's inputs, then check the settled outputs.
    task automatic cyc(input string tag, input logic rdy, input logic [6:0] op,
                       input logic [3:0] st, input logic [16:0] c, input logic [31:0] cnt);
        @(posedge clk);
        #2;
        mem_ready_i = rdy;
        opcode_i    = op;
        #1;
        expect_now(tag, st, c, cnt);
    endtask

    always @(negedge clk) begin
        if (rst_i === 1'b0) begin
            chk("mutex_rw", {31'b0, MemRead_o & MemWrite_o}, 32'd0);
            chk("regwr_fd", {31'b0, RegWrite_o & (state_o == 4'd1 || state_o == 4'd2)}, 32'd0);
        end
    end

    initial begin
        rst_i = 1'b1;
        mem_ready_i = 1'b0;
        opcode_i = 7'b0;
        repeat (2) @(posedge clk);
        #2;
        expect_now("reset", 4'd0, C_IDLE, 0);
        rst_i = 1'b0;
        mem_ready_i = 1'b1;
        opcode_i = OP_R;
        #1;
        expect_now("idle", 4'd0, C_IDLE, 0);

        // R-type
        cyc("r.fetch",  1, OP_R, 4'd1, C_FETCH_R, 0);
        cyc("r.decode", 1, OP_R, 4'd2, C_DECODE,  0);
        cyc("r.exec",   1, OP_R, 4'd7, C_EXEC_R,  0);
        cyc("r.wb",     1, OP_R, 4'd9, C_ALU_WB,  0);

        // LD: 2 fetch waits, 3 MEM_RD waits -> 10 cycles
        cyc("ld.fetch0", 0, OP_LD, 4'd1, C_FETCH_W, 1);
        cyc("ld.fetch1", 0, OP_LD, 4'd1, C_FETCH_W, 1);
        cyc("ld.fetch2", 1, OP_LD, 4'd1, C_FETCH_R, 1);
        cyc("ld.decode", 0, OP_LD, 4'd2, C_DECODE,  1);
        cyc("ld.addr",   0, OP_LD, 4'd3, C_MADDR,   1);
        cyc("ld.rd0",    0, OP_LD, 4'd4, C_MEM_RD,  1);
        cyc("ld.rd1",    0, OP_LD, 4'd4, C_MEM_RD,  1);
        cyc("ld.rd2",    0, OP_LD, 4'd4, C_MEM_RD,  1);
        cyc("ld.rd3",    1, OP_LD, 4'd4, C_MEM_RD,  1);
        cyc("ld.wb",     1, OP_LD, 4'd5, C_MEM_WB,  1);

        // SD with one write wait: retire only in the handshake cycle
        cyc("sd.fetch",  1, OP_SD, 4'd1, C_FETCH_R, 2);
        cyc("sd.decode", 1, OP_SD, 4'd2, C_DECODE,  2);
        cyc("sd.addr",   0, OP_SD, 4'd3, C_MADDR,   2);
        cyc("sd.wr0",    0, OP_SD, 4'd6, C_MWR_W,   2);
        cyc("sd.wr1",    1, OP_SD, 4'd6, C_MWR_R,   2);

        // BEQ
        cyc("beq.fetch",  1, OP_BEQ, 4'd1,  C_FETCH_R, 3);
        cyc("beq.decode", 1, OP_BEQ, 4'd2,  C_DECODE,  3);
        cyc("beq.branch", 1, OP_BEQ, 4'd10, C_BRANCH,  3);

        // OP-IMM
        cyc("i.fetch",  1, OP_I, 4'd1, C_FETCH_R, 4);
        cyc("i.decode", 1, OP_I, 4'd2, C_DECODE,  4);
        cyc("i.exec",   1, OP_I, 4'd8, C_EXEC_I,  4);
        cyc("i.wb",     1, OP_I, 4'd9, C_ALU_WB,  4);

        // Illegal opcode -> absorbing TRAP, counter frozen
        cyc("bad.fetch",  1, OP_BAD, 4'd1, C_FETCH_R, 5);
        cyc("bad.decode", 1, OP_BAD, 4'd2, C_DECODE,  5);
        for (int i = 0; i < 22; i++) cyc("trap", 1, OP_BAD, 4'd11, C_TRAP, 5);
        #1 rst_i = 1'b1;
        #1 expect_now("trap.rst", 4'd0, C_IDLE, 0);
        #1 rst_i = 1'b0;
        cyc("post.fetch", 1, OP_LD, 4'd1, C_FETCH_R, 0);

        // Async reset mid-MEM_RD
        cyc("ld2.decode", 1, OP_LD, 4'd2, C_DECODE, 0);
        cyc("ld2.addr",   0, OP_LD, 4'd3, C_MADDR,  0);
        cyc("ld2.rd",     0, OP_LD, 4'd4, C_MEM_RD, 0);
        #2 rst_i = 1'b1;
        #1 expect_now("async.rst", 4'd0, C_IDLE, 0);
        @(posedge clk);
        #2 rst_i = 1'b0;
        #1 expect_now("async.idle", 4'd0, C_IDLE, 0);
        cyc("async.fetch", 1, OP_R, 4'd1, C_FETCH_R, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
